// File: rtl/bus_memory_responder_if.sv
// bus_memory_responder_if: valid/ready request/response bus between an
// initiator (the core) and the memory responder. The clock and reset stay
// outside the interface as plain ports.
interface bus_memory_responder_if;
  logic        bus_vaild;
  logic        bus_ready;
  logic        bus_write_enable;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [31:0] bus_data;

  modport master (
    output bus_vaild,
    output bus_write_enable,
    output bus_address,
    output bus_write_data,
    input  bus_ready,
    input  bus_data
  );

  modport slave (
    input  bus_vaild,
    input  bus_write_enable,
    input  bus_address,
    input  bus_write_data,
    output bus_ready,
    output bus_data
  );
endinterface

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: word-addressed memory target on the core's valid/ready
// bus. One request at a time. After acceptance, WAIT_STATES wait cycles are
// inserted, then one RESPOND cycle. The completion edge is the edge that leaves
// RESPOND. On that edge, bus_ready rises for one cycle, read data is registered
// and writes are committed.
// Because the commit happens on the edge that leaves RESPOND, a reset in WAIT or
// RESPOND drops a pending write.
// Optional feature: define BUS_RESPONDER_RANDOM_WAIT_EN to add 0-3 pseudo-random
// extra wait cycles per request. They come from a 16-bit Fibonacci LFSR.
// Memory contents are not cleared by reset; only control state and outputs are.
module bus_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  bus_memory_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Wide enough for 15 fixed wait states plus 3 random extra cycles.
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e             state_r;
  state_e             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [CNT_W-1:0]   load_cnt_s;
  logic [IDX_W-1:0]   idx_r;
  logic               we_r;
  logic               ready_r;
  logic [31:0]        data_r;
  logic               accept_s;
  logic               complete_s;
  logic [31:0]        mem_r [DEPTH_WORDS];

  // Address bits below the word and above the index are don't-care (aliasing).
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{bus.bus_address[31:IDX_W+2], bus.bus_address[1:0]};

`ifdef BUS_RESPONDER_RANDOM_WAIT_EN
  logic [15:0] lfsr_r;

  // One Fibonacci step with taps 16,14,13,11, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // LFSR steps once per accepted request, so the extra wait sequence is
  // tied to transfers, not to elapsed time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
    end else if (accept_s) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign load_cnt_s = CNT_W'(WAIT_STATES) + {3'b000, lfsr_r[1:0]};
`else
  assign load_cnt_s = CNT_W'(WAIT_STATES);
`endif

  // FSM state and wait counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, complete from RESPOND.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    complete_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.bus_vaild) begin
          accept_s   = 1'b1;
          cnt_next_s = load_cnt_s;
          if (load_cnt_s == 5'd0) begin
            state_next_s = RESPOND;
          end else begin
            state_next_s = WAIT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        // A zero count cannot occur here normally; treat it like the last cycle.
        if (cnt_r <= 5'd1) begin
          cnt_next_s   = 5'd0;
          state_next_s = RESPOND;
        end else begin
          cnt_next_s   = cnt_r - 5'd1;
          state_next_s = WAIT;
        end
      end
      RESPOND: begin
        complete_s   = 1'b1;
        cnt_next_s   = 5'd0;
        state_next_s = IDLE;
      end
      default: begin
        cnt_next_s   = 5'd0;
        state_next_s = IDLE;
      end
    endcase
  end

  // Capture the word index and direction at acceptance; later bus changes are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_r <= {IDX_W{1'b0}};
      we_r  <= 1'b0;
    end else if (accept_s) begin
      idx_r <= bus.bus_address[IDX_W+1:2];
      we_r  <= bus.bus_write_enable;
    end else begin
      idx_r <= idx_r;
      we_r  <= we_r;
    end
  end

  // Completion pulse and registered read data; writes leave bus_data untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_r <= 1'b0;
      data_r  <= 32'h0000_0000;
    end else begin
      ready_r <= complete_s;
      if (complete_s && !we_r) begin
        data_r <= mem_r[idx_r];
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Memory array: no reset. A write commits only on a real completion edge.
  always_ff @(posedge clock) begin
    if (complete_s && we_r) begin
      mem_r[idx_r] <= bus.bus_write_data;
    end
  end

  assign bus.bus_ready = ready_r;
  assign bus.bus_data  = data_r;

endmodule

// File: tb/tb_bus_memory_responder.sv
// tb_bus_memory_responder: scoreboard bench for two responders (0 and 3 wait
// states). The driver computes each request's completion cycle and data with a
// transaction-level model and pushes them to a queue. A monitor pops and
// compares on every bus_ready.
module tb_bus_memory_responder;

  localparam int DEPTH = 1024;
  localparam int WS0   = 0;
  localparam int WS1   = 3;

  logic        clock = 1'b0;
  logic        rst0;
  logic        rst1;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  bus_memory_responder_if b0 ();
  bus_memory_responder_if b1 ();

  bus_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .clock(clock), .reset(rst0), .bus(b0));
  bus_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .clock(clock), .reset(rst1), .bus(b1));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    bit          rd;
    bit          known;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mm [int];
  int unsigned free_edge [2];
  logic [31:0] last_rd [2];
  bit          last_known [2];
  logic [15:0] lf [2];
  bit          prev_r [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference LFSR written with shifts and masks on an integer value.
  function automatic logic [15:0] lfsr_model(input logic [15:0] v);
    int x;
    int fb;
    x  = int'(v);
    fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return 16'(((x << 1) | fb) & 16'hFFFF);
  endfunction

  function automatic bit rdy(input int u);
    return (u == 0) ? b0.bus_ready : b1.bus_ready;
  endfunction

  function automatic logic [31:0] rdata(input int u);
    return (u == 0) ? b0.bus_data : b1.bus_data;
  endfunction

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic drive(input int u, input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (u == 0) begin
      b0.bus_vaild = v; b0.bus_write_enable = we; b0.bus_address = a; b0.bus_write_data = wd;
    end else begin
      b1.bus_vaild = v; b1.bus_write_enable = we; b1.bus_address = a; b1.bus_write_data = wd;
    end
  endtask

  task automatic set_valid(input int u, input bit v);
    if (u == 0) b0.bus_vaild = v;
    else        b1.bus_vaild = v;
  endtask

  // Issue one request from a negedge. keep leaves valid high for a back-to-back
  // request. glitch drops valid and scrambles address/direction after acceptance.
  task automatic issue(input int u, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit keep, input bit glitch);
    exp_t        e;
    int unsigned acc;
    int unsigned w;
    int          key;
    bit          got;
    acc = cyc + 1;
    if (free_edge[u] > acc) acc = free_edge[u];
    w = (u == 0) ? WS0 : WS1;
`ifdef BUS_RESPONDER_RANDOM_WAIT_EN
    w = w + (int'(lf[u]) % 4);
    lf[u] = lfsr_model(lf[u]);
`endif
    e.due = acc + 1 + w;
    free_edge[u] = e.due + 1;
    key = u * DEPTH + int'((addr / 4) % DEPTH);
    e.rd = !we;
    if (we) begin
      e.known = last_known[u];
      e.data  = last_rd[u];
      mm[key] = wd;
    end else if (mm.exists(key)) begin
      e.known = 1'b1;
      e.data  = mm[key];
      last_rd[u] = mm[key];
      last_known[u] = 1'b1;
    end else begin
      e.known = 1'b0;
      e.data  = 32'h0;
      last_known[u] = 1'b0;
    end
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(u, 1'b1, we, addr, wd);
    if (glitch) begin
      @(negedge clock);
      drive(u, 1'b0, ~we, $urandom, wd);
    end
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clock);
      if (rdy(u)) got = 1'b1;
    end
    chk($sformatf("u%0d_handshake_done", u), {31'd0, got}, 32'd1);
    if (!keep) set_valid(u, 1'b0);
  endtask

  // Monitor: every bus_ready pops one expectation and checks timing and data.
  always @(negedge clock) begin : monitor
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (rdy(u)) begin
        chk($sformatf("u%0d_ready_not_consecutive", u), {31'd0, prev_r[u]}, 32'd0);
        if (qsize(u) == 0) begin
          chk($sformatf("u%0d_unexpected_ready", u), 32'd1, 32'd0);
        end else begin
          if (u == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("u%0d_ready_cycle", u), cyc, e.due);
          if (e.known)
            chk($sformatf("u%0d_%s", u, e.rd ? "read_data" : "data_hold_on_write"), rdata(u), e.data);
        end
      end
      prev_r[u] <= rdy(u);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a;
    logic [31:0] wd;
    bit          we;
    bit          keep;
    bit          glitch;
    logic [31:0] idx_mask;
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int u = 0; u < 2; u++) begin
      lf[u] = 16'hACE1;
      last_rd[u] = 32'h0;
      last_known[u] = 1'b1;
      prev_r[u] = 1'b0;
    end
    repeat (3) @(negedge clock);
    chk("u0_reset_ready", {31'd0, b0.bus_ready}, 32'd0);
    chk("u0_reset_data", b0.bus_data, 32'h0);
    chk("u1_reset_ready", {31'd0, b1.bus_ready}, 32'd0);
    chk("u1_reset_data", b1.bus_data, 32'h0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    free_edge[0] = cyc + 1;
    free_edge[1] = cyc + 1;

    // Write/read and aliasing on the zero-wait responder.
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
    issue(0, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 1'b0);
    issue(0, 1'b0, 32'h0000_1007, 32'h0, 1'b0, 1'b0);
    // Four back-to-back reads with valid held high.
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0);
    issue(0, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 1'b0);
    issue(0, 1'b0, 32'h0000_1010, 32'h0, 1'b1, 1'b0);
    issue(0, 1'b0, 32'h0000_2004, 32'h0, 1'b0, 1'b0);

    // Three-wait-state responder: latency, then reset during a pending write.
    issue(1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0);
    issue(1, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(negedge clock);
    @(negedge clock);
    rst1 = 1'b1;
    #1;
    chk("u1_midreset_ready", {31'd0, b1.bus_ready}, 32'd0);
    chk("u1_midreset_data", b1.bus_data, 32'h0);
    repeat (3) begin
      @(negedge clock);
      chk("u1_in_reset_ready", {31'd0, b1.bus_ready}, 32'd0);
    end
    lf[1] = 16'hACE1;
    last_rd[1] = 32'h0;
    last_known[1] = 1'b1;
    rst1 = 1'b0;
    free_edge[1] = cyc + 1;
    // Valid is high at release: accepted at the first edge.
    issue(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 1'b0);
    // Valid dropped during WAIT: the write must still complete.
    issue(1, 1'b1, 32'h0000_0024, 32'hA5A5_5A5A, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h0000_0024, 32'h0, 1'b0, 1'b0);

    // Randomized traffic over 16 words with random aliasing address bits.
    idx_mask = 32'(DEPTH - 1) << 2;
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 30; k++) begin
        we     = 1'($urandom_range(0, 1));
        a      = ($urandom & ~idx_mask) | (32'($urandom_range(0, 15)) << 2);
        wd     = $urandom;
        keep   = (k < 29) && ($urandom_range(0, 1) == 1);
        glitch = !keep && ($urandom_range(0, 3) == 0);
        issue(u, we, a, wd, keep, glitch);
      end
    end

    repeat (4) @(negedge clock);
    chk("u0_queue_drained", 32'(q0.size()), 32'd0);
    chk("u1_queue_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
